// File: rtl/gear_ecu_n16_r2_p4_pkg.sv
// Shared types and constants for the GeAr(16,2,4) error-correction sequencer.
package gear_pkg;

  localparam int GEAR_N    = 16;
  localparam int GEAR_R    = 2;
  localparam int GEAR_P    = 4;
  localparam int GEAR_NSUB = 6;
  localparam int GEAR_SUBW = GEAR_R + GEAR_P;   // operand bits per sub-adder
  localparam int GEAR_FW   = GEAR_NSUB - 1;     // sub-adders 1..5 can mispredict
  localparam int GEAR_ITW  = 3;                 // wide enough for 0..GEAR_FW

  typedef logic [GEAR_FW:1]     flag_t;
  typedef logic [GEAR_N:0]      sum_t;
  typedef logic [GEAR_ITW-1:0]  iter_t;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  // Isolate the lowest set flag so corrections proceed from the LSB side,
  // letting cascades ripple upward one sub-adder per pass.
  function automatic flag_t lowest_flag(flag_t v);
    return v & (~v + flag_t'(1));
  endfunction

endpackage

// File: rtl/gear_ecu_n16_r2_p4_if.sv
// Operand/result handshake bundle: producer/consumer side is master, block is slave.
interface gear_ecu_n16_r2_p4_if;
  import gear_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [GEAR_N-1:0] in1;
  logic [GEAR_N-1:0] in2;
  logic              approx_mode;
  logic              out_valid;
  logic              out_ready;
  sum_t              res;
  logic              out_err;
  iter_t             out_iter;

  modport master (
    output in_valid, in1, in2, approx_mode, out_ready,
    input  in_ready, out_valid, res, out_err, out_iter
  );

  modport slave (
    input  in_valid, in1, in2, approx_mode, out_ready,
    output in_ready, out_valid, res, out_err, out_iter
  );

endinterface

// File: rtl/gear_ecu_n16_r2_p4_cin.sv
// GeAr(16,2,4) datapath with per-sub-adder carry-in injection and error flags.
// Purely combinational; one instance is driven by the sequencer registers.
module gear_n16_r2_p4_cin
  import gear_pkg::*;
(
  input  logic [GEAR_N-1:0] in1,
  input  logic [GEAR_N-1:0] in2,
  input  flag_t             cin,
  output sum_t              res,
  output flag_t             err
);

  logic [GEAR_NSUB-1:0][GEAR_SUBW:0] t;
  logic [GEAR_NSUB-1:0]              ci;

  // Sub-adder 0 never receives a carry-in.
  assign ci = {cin, 1'b0};

  for (genvar k = 0; k < GEAR_NSUB; k++) begin : g_sub
    localparam int LO = GEAR_R * k;

    assign t[k] = {1'b0, in1[LO+GEAR_SUBW-1:LO]}
                + {1'b0, in2[LO+GEAR_SUBW-1:LO]}
                + {{GEAR_SUBW{1'b0}}, ci[k]};

    if (k == 0) begin : g_first
      assign res[GEAR_SUBW-1:0] = t[0][GEAR_SUBW-1:0];
    end else begin : g_rest
      // Low P bits overlap the previous sub-adder and are discarded.
      logic [GEAR_P-1:0] unused_lsb;
      assign unused_lsb = t[k][GEAR_P-1:0];

      assign res[LO+GEAR_SUBW-1:LO+GEAR_P] = t[k][GEAR_SUBW-1:GEAR_P];

      // Mispredict: real carry arrives into a window that fully propagates it,
      // but this sub-adder assumed zero and has not been corrected yet.
      assign err[k] = t[k-1][GEAR_SUBW]
                    & (&(in1[LO+GEAR_P-1:LO] ^ in2[LO+GEAR_P-1:LO]))
                    & ~ci[k];
    end
  end

  assign res[GEAR_N] = t[GEAR_NSUB-1][GEAR_SUBW];

endmodule

// File: rtl/gear_ecu_n16_r2_p4.sv
// GeAr(16,2,4) error-detection-and-correction sequencer.
// Accepts one operand pair, evaluates the approximate sum, then injects
// carry-in into one mispredicting sub-adder per cycle until exact (or until
// MAX_ITER corrections, legal 1..5). Optional saturating correction counter
// on err_cnt when GEAR_ECU_ERRCNT_EN is defined.
module gear_ecu_n16_r2_p4
  import gear_pkg::*;
#(
  parameter int MAX_ITER = 5
) (
  input logic               clk,
  input logic               rst,
  gear_ecu_n16_r2_p4_if.slave bus
`ifdef GEAR_ECU_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  state_t            state_q;
  logic [GEAR_N-1:0] in1_q, in2_q;
  logic              amode_q;
  flag_t             cin_q, cin_d, err;
  iter_t             iter_q, iter_d;
  sum_t              sum, res_q;
  logic              in_ready_q, out_valid_q, out_err_q;
  iter_t             out_iter_q;
  logic              accept, finish, handshake;

  gear_n16_r2_p4_cin u_sum (
    .in1 (in1_q),
    .in2 (in2_q),
    .cin (cin_q),
    .res (sum),
    .err (err)
  );

  // Next correction step: force carry-in on the lowest flagged sub-adder.
  always_comb begin
    cin_d  = cin_q | lowest_flag(err);
    iter_d = iter_q + iter_t'(1);
  end

  assign accept    = (state_q == IDLE) && in_ready_q && bus.in_valid;
  assign finish    = (err == '0) || amode_q || (iter_q == iter_t'(MAX_ITER));
  assign handshake = (state_q == DONE) && bus.out_ready;

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      out_err_q   <= 1'b0;
      out_iter_q  <= '0;
      cin_q       <= '0;
      iter_q      <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      amode_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            in1_q      <= bus.in1;
            in2_q      <= bus.in2;
            amode_q    <= bus.approx_mode;
            cin_q      <= '0;
            iter_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= EVAL;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        EVAL: begin
          // iter is zero only on the first pass, where the raw prediction is judged.
          if (iter_q == '0) out_err_q <= |err;
          if (finish) begin
            res_q       <= sum;
            out_iter_q  <= iter_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cin_q  <= cin_d;
            iter_q <= iter_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_iter  = out_iter_q;

`ifdef GEAR_ECU_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;

  assign err_sum   = {1'b0, err_cnt_q} + 17'(out_iter_q);
  assign err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  // Accumulate corrections of each delivered result, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst)            err_cnt_q <= '0;
    else if (handshake) err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_hs;
  assign unused_hs = handshake;
`endif

endmodule

// File: tb/tb_gear_ecu_n16_r2_p4.sv
// Scoreboard bench for gear_ecu_n16_r2_p4: directed operand pairs push their
// hand-computed result, a monitor pops and compares on each delivered result.
module tb_gear_ecu_n16_r2_p4;
  import gear_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gear_ecu_n16_r2_p4_if bus ();

`ifdef GEAR_ECU_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  gear_ecu_n16_r2_p4 #(.MAX_ITER(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef GEAR_ECU_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  typedef struct {
    logic [16:0] res;
    logic        err;
    logic [2:0]  iter;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter and accept-edge stamp for latency measurement.
  always @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) acc_cyc <= cyc + 1;
    cyc <= cyc + 1;
  end

  // Monitor: sample just after the falling edge, compare against queue head.
  initial begin
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen = 1'b0;
      end else if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", cyc + 1 - acc_cyc, sb[0].lat);
          end
          chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
          chk("res", {15'd0, bus.res}, {15'd0, sb[0].res});
          if (bus.out_ready) begin
            chk("out_err", {31'd0, bus.out_err}, {31'd0, sb[0].err});
            chk("out_iter", {29'd0, bus.out_iter}, {29'd0, sb[0].iter});
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m,
                      input bit push, input logic [16:0] r, input logic e,
                      input logic [2:0] it);
    exp_t x;
    int   t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in1         = a;
    bus.in2         = b;
    bus.approx_mode = m;
    bus.in_valid    = 1'b1;
    if (push) begin
      x.res  = r;
      x.err  = e;
      x.iter = it;
      x.lat  = int'(it) + 2;
      sb.push_back(x);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd0);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_res"},       {15'd0, bus.res},       32'd0);
    chk({tag, "_out_err"},   {31'd0, bus.out_err},   32'd0);
    chk({tag, "_out_iter"},  {29'd0, bus.out_iter},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.in_valid    = 1'b0;
    bus.in1         = '0;
    bus.in2         = '0;
    bus.approx_mode = 1'b0;
    bus.out_ready   = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // 1: no mispredict
    send(16'h0001, 16'h0002, 1'b0, 1'b1, 17'h00003, 1'b0, 3'd0);
    drain();
    // 2: two corrections, cin[1] then cin[2]
    send(16'h0003, 16'h00FD, 1'b0, 1'b1, 17'h00100, 1'b1, 3'd2);
    drain();
    // 3: five cascading corrections
    send(16'h0001, 16'hFFFF, 1'b0, 1'b1, 17'h10000, 1'b1, 3'd5);
    drain();
    // 4: approximate-only returns the uncorrected sum
    send(16'h0001, 16'hFFFF, 1'b1, 1'b1, 17'h0FFC0, 1'b1, 3'd0);
    drain();
    // full-width carries with no propagate window: exact on first pass
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 17'h1FFFE, 1'b0, 3'd0);
    drain();
    send(16'h1234, 16'h4321, 1'b0, 1'b1, 17'h05555, 1'b0, 3'd0);
    drain();

    // 5: backpressure with an ignored in_valid during DONE
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(16'h0003, 16'h00FD, 1'b0, 1'b1, 17'h00100, 1'b1, 3'd2);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      bus.in1      = 16'h0001;
      bus.in2      = 16'h0002;
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_out_valid_after_hs", {31'd0, bus.out_valid}, 32'd0);
    drain();

    // 6: reset during EVAL discards the operation
    send(16'h0001, 16'hFFFF, 1'b0, 1'b0, 17'h0, 1'b0, 3'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready_release", {31'd0, bus.in_ready}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_out_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef GEAR_ECU_ERRCNT_EN
    chk("err_cnt_after_reset", {16'd0, err_cnt}, 32'd0);
`endif
    send(16'h0001, 16'h0002, 1'b0, 1'b1, 17'h00003, 1'b0, 3'd0);
    drain();
    send(16'h0003, 16'h00FD, 1'b0, 1'b1, 17'h00100, 1'b1, 3'd2);
    drain();
`ifdef GEAR_ECU_ERRCNT_EN
    chk("err_cnt_after_s2", {16'd0, err_cnt}, 32'd2);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gear_ecu_n16_r2_p4.md
Name: gear_ecu_n16_r2_p4

Overview:
Error-detection-and-correction sequencer for the 16-bit GeAr approximate adder (R=2, P=4, six 6-bit sub-adders). It accepts an operand pair and evaluates the approximate sum. It then iteratively injects carry-in into mispredicting sub-adders, one per cycle, until the sum is exact. The block sits between an operand producer and a result consumer, with valid/ready on both sides. An approximate-only mode returns the uncorrected sum.

Parameters:
MAX_ITER, 5, correction-cycle ceiling; 5 is the worst case for 6 sub-adders. Legal range 1..5.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
in1  in  16  operand A
in2  in  16  operand B
approx_mode  in  1  sampled with operands; 1 = skip correction
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
res  out  17  sum
out_err  out  1  first evaluation flagged at least one error
out_iter  out  3  number of corrections applied

Behaviour:
- Sub-adder k (k=0..5) adds bits [2k+5:2k] of in1 and in2, plus cin[k], giving a 7-bit result t_k.
  - res[5:0] = t_0[5:0].
  - res[2k+5:2k+4] = t_k[5:4] for k=1..5.
  - res[16] = t_5[6].
  - cin[0] is tied to 0.
- Error flag: E_k = t_{k-1}[6] & (&(in1[2k+3:2k]^in2[2k+3:2k])) & ~cin[k], for k=1..5.
- Reset values: in_ready=0 during reset and 1 the cycle after. out_valid=0, res=0, out_err=0, out_iter=0. Internal cin=0, state=IDLE.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch in1, in2 and approx_mode, clear cin and iter, then go to EVAL.
  - EVAL: in_ready=0; flags are evaluated from the registered operands and cin.
    - On the first EVAL cycle, out_err is registered as |E.
    - If E==0, approx_mode=1, or iter==MAX_ITER: register res, go to DONE.
    - Otherwise: set cin[k] for the lowest k with E_k=1, increment iter, and stay in EVAL.
  - DONE: out_valid=1. res, out_err and out_iter are held stable until out_ready=1, then go to IDLE.
  - out_iter reports the final iter.
- Latency: the accept edge to out_valid is 2 cycles plus out_iter.
- Throughput: one operation in flight. There is no overlap; in_ready is low from EVAL through DONE.
- If in_valid is high during DONE, the input is ignored and in_ready stays low.
- Cascades: a correction may raise a new E_{k+1}. This is handled by the next EVAL iteration.
- If MAX_ITER is less than the corrections needed, the result is partially corrected and out_iter = MAX_ITER.
- Reset mid-operation: rst in any state returns to IDLE with reset values. The pending operation is discarded and no out_valid is produced.
- Simultaneous out_ready and the DONE entry cycle: out_valid is first asserted in DONE, so a handshake needs out_ready high in a DONE cycle.

Optional Feature:
GEAR_ECU_ERRCNT_EN
- Defined: adds output err_cnt [15:0]. It adds out_iter on each completed out handshake and saturates at 0xFFFF. It clears on rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gear_pkg holds:
  - constants GEAR_N=16, GEAR_R=2, GEAR_P=4, GEAR_NSUB=6;
  - state enum {IDLE, EVAL, DONE};
  - the cin/flag vector width.
- Sub-module gear_n16_r2_p4_cin: purely combinational. Inputs are in1, in2 and cin[5:1]. Outputs are res[16:0] and err[5:1]. The controller instantiates it once.

Test Plan:
1. in1=0x0001, in2=0x0002, approx_mode=0 -> res=0x00003, out_err=0, out_iter=0; out_valid 2 cycles after accept.
2. in1=0x0003, in2=0x00FD -> approximate sum 0x000C0 flagged. Corrections cin[1] then cin[2]. res=0x00100, out_err=1, out_iter=2; out_valid 4 cycles after accept.
3. in1=0x0001, in2=0xFFFF -> five cascading corrections. res=0x10000, out_iter=5; out_valid 7 cycles after accept.
4. Same operands as scenario 3 with approx_mode=1 -> res=0x0FFC0, out_err=1, out_iter=0, 2-cycle latency.
5. Backpressure: complete scenario 2 with out_ready=0 for 5 cycles -> out_valid and res stay stable, in_ready stays 0, and a new in_valid is ignored. The handshake completes on out_ready=1, then in_ready=1 the next cycle.
6. Assert rst during EVAL of scenario 3 -> out_valid never rises and outputs return to reset values. After reset release, scenario 1 completes correctly. With GEAR_ECU_ERRCNT_EN defined, err_cnt = 0 after reset and 2 after scenario 2.
